// File: rtl/score_counter_bcd_pkg.sv
// ---------------------------------------------------------------------------
// score_pkg
// Shared definitions for the BCD score engine:
//   BCD_W / BCD_MAX  - width and largest value of one BCD digit
//   bcd_vec_t        - widest packed BCD vector handled by bcd_gt (16 digits)
//   drain_state_t    - bonus drain state machine encoding
//   bcd_gt(a, b)     - 1 when packed BCD a is numerically greater than b
// ---------------------------------------------------------------------------
package score_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
    localparam int BCD_VEC_DIGITS = 16;

    typedef logic [BCD_W*BCD_VEC_DIGITS-1:0] bcd_vec_t;

    typedef enum logic {
        S_IDLE,
        S_DRAIN
    } drain_state_t;

    // The most significant differing digit decides; for valid BCD this is the
    // same as a numeric compare. Narrower scores are zero-extended by callers.
    function automatic logic bcd_gt(input bcd_vec_t a, input bcd_vec_t b);
        logic gt;
        logic decided;
        gt      = 1'b0;
        decided = 1'b0;
        for (int i = BCD_VEC_DIGITS - 1; i >= 0; i--) begin
            if (!decided && (a[i*BCD_W +: BCD_W] != b[i*BCD_W +: BCD_W])) begin
                gt      = a[i*BCD_W +: BCD_W] > b[i*BCD_W +: BCD_W];
                decided = 1'b1;
            end
        end
        return gt;
    endfunction

endpackage

// File: rtl/score_counter_bcd_incrementer.sv
// ---------------------------------------------------------------------------
// bcd_incrementer
// Combinational +1 on a packed BCD value (digit 0 in bits [3:0]).
//   value     in   BCD_W*DIGITS  packed BCD operand
//   value_inc out  BCD_W*DIGITS  value + 1, wrapping all-9s to all-0s
//   carry_out out  1             1 iff value is all 9s
// ---------------------------------------------------------------------------
module bcd_incrementer
    import score_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic [BCD_W*DIGITS-1:0] value,
    output logic [BCD_W*DIGITS-1:0] value_inc,
    output logic                    carry_out
);

    logic carry;

    // Ripple the carry from digit 0 upward: a 9 rolls to 0 and passes the
    // carry on, the first non-9 digit absorbs it.
    always_comb begin
        carry     = 1'b1;
        value_inc = value;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (value[i*BCD_W +: BCD_W] == BCD_MAX) begin
                    value_inc[i*BCD_W +: BCD_W] = '0;
                end else begin
                    value_inc[i*BCD_W +: BCD_W] = value[i*BCD_W +: BCD_W] + BCD_W'(1);
                    carry = 1'b0;
                end
            end
        end
        carry_out = carry;
    end

endmodule

// File: rtl/score_counter_bcd.sv
// ---------------------------------------------------------------------------
// score_counter_bcd
// Game score engine: a prescaler produces auto-increment ticks, a handshaked
// bonus port queues extra points that drain one per cycle, and the score is
// kept in packed BCD with a high score latched on round clear.
//   clk          in   1        system clock
//   rst_n        in   1        asynchronous active-low reset
//   run          in   1        1 = counting; 0 = prescaler and drain frozen
//   clear        in   1        round clear: update high score, zero score
//   bonus_valid  in   1        bonus request
//   bonus_pts    in   PTS_W    bonus points, binary
//   bonus_ready  out  1        bonus accepted this cycle if valid
//   tick         out  1        one-cycle pulse per prescaler terminal count
//   score_bcd    out  4*DIGITS current score, packed BCD
//   high_bcd     out  4*DIGITS high score, packed BCD
//   saturated    out  1        sticky: increment blocked at max (WRAP_MODE=0)
//   overflow     out  1        one-cycle pulse on wrap to zero (WRAP_MODE=1)
// ---------------------------------------------------------------------------
module score_counter_bcd
    import score_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int DIGITS    = 4,
    parameter int PTS_W     = 4,
    parameter int WRAP_MODE = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    run,
    input  logic                    clear,
    input  logic                    bonus_valid,
    input  logic [PTS_W-1:0]        bonus_pts,
    output logic                    bonus_ready,
    output logic                    tick,
    output logic [BCD_W*DIGITS-1:0] score_bcd,
    output logic [BCD_W*DIGITS-1:0] high_bcd,
    output logic                    saturated,
    output logic                    overflow
);

    localparam int SCORE_W = BCD_W * DIGITS;
    localparam int PRESC_W = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] presc_q;
    logic [PTS_W-1:0]   pending_q, pending_d;
    drain_state_t       state_q, state_d;

    logic               tick_hit;
    logic               drain_step;
    logic               inc_req;
    logic               transfer;
    logic [SCORE_W-1:0] score_inc;
    logic               score_carry;
    bcd_vec_t           score_ext;
    bcd_vec_t           high_ext;

    // Value the score takes on an increment request. score_inc already wraps
    // all-9s to zero, so only the saturating case needs to pick another value.
    function automatic logic [SCORE_W-1:0] sat_or_wrap(
        input logic [SCORE_W-1:0] cur,
        input logic [SCORE_W-1:0] inc,
        input logic               at_max
    );
        if (!at_max) begin
            return inc;
        end
        return (WRAP_MODE != 0) ? '0 : cur;
    endfunction

    bcd_incrementer #(
        .DIGITS(DIGITS)
    ) u_inc (
        .value    (score_bcd),
        .value_inc(score_inc),
        .carry_out(score_carry)
    );

    always_comb begin
        score_ext = '0;
        high_ext  = '0;
        score_ext[SCORE_W-1:0] = score_bcd;
        high_ext[SCORE_W-1:0]  = high_bcd;
    end

    // Increment arbitration: a tick always wins the single +1 slot and the
    // drain simply waits a cycle, so no point is ever dropped. clear kills
    // both (a tick on the clear cycle is discarded).
    always_comb begin
        tick_hit   = run && !clear && (presc_q == PRESC_LAST);
        drain_step = (state_q == S_DRAIN) && run && !clear && !tick_hit;
        inc_req    = tick_hit || drain_step;
        transfer   = bonus_valid && bonus_ready;
    end

    assign bonus_ready = (pending_q == '0) && !clear;

    // Drain state machine: next state and pending count
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        if (clear) begin
            state_d   = S_IDLE;
            pending_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (transfer) begin
                        pending_d = bonus_pts;
                        // Zero-point bonus is accepted but leaves us idle.
                        if (bonus_pts != '0) begin
                            state_d = S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_step) begin
                        pending_d = pending_q - PTS_W'(1);
                        if (pending_q == PTS_W'(1)) begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: begin
                    state_d   = S_IDLE;
                    pending_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    // Registered score, prescaler and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            tick      <= 1'b0;
            score_bcd <= '0;
            high_bcd  <= '0;
            saturated <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            tick     <= tick_hit;
            overflow <= 1'b0;
            if (clear) begin
                if (bcd_gt(score_ext, high_ext)) begin
                    high_bcd <= score_bcd;
                end
                score_bcd <= '0;
                presc_q   <= '0;
                saturated <= 1'b0;
            end else begin
                if (run) begin
                    presc_q <= tick_hit ? '0 : presc_q + PRESC_W'(1);
                end
                if (inc_req) begin
                    score_bcd <= sat_or_wrap(score_bcd, score_inc, score_carry);
                    if (score_carry) begin
                        if (WRAP_MODE != 0) begin
                            overflow <= 1'b1;
                        end else begin
                            saturated <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_score_counter_bcd.sv
// ---------------------------------------------------------------------------
// tb_score_counter_bcd
// Three instances share clk/rst_n but have their own control inputs:
//   0: TICK_DIV=4,    DIGITS=2, saturating
//   1: TICK_DIV=4,    DIGITS=2, wrapping
//   2: TICK_DIV=1000, DIGITS=2, saturating (bonus/clear work without ticks)
// A cycle-level integer model of each instance is checked every cycle, and
// directed sequences add literal expectations.
// ---------------------------------------------------------------------------
module tb_score_counter_bcd;

    localparam int MAXV = 99;

    logic clk;
    logic rst_n;

    logic       run_a   [3];
    logic       clear_a [3];
    logic       bval_a  [3];
    logic [3:0] bpts_a  [3];

    wire        ready_w [3];
    wire        tick_w  [3];
    wire  [7:0] score_w [3];
    wire  [7:0] high_w  [3];
    wire        sat_w   [3];
    wire        ovf_w   [3];

    int tdiv  [3] = '{4, 4, 1000};
    int wraps [3] = '{0, 1, 0};

    int n_run  = 0;
    int n_fail = 0;

    score_counter_bcd #(.TICK_DIV(4), .DIGITS(2), .PTS_W(4), .WRAP_MODE(0)) dut_sat (
        .clk(clk), .rst_n(rst_n), .run(run_a[0]), .clear(clear_a[0]),
        .bonus_valid(bval_a[0]), .bonus_pts(bpts_a[0]), .bonus_ready(ready_w[0]),
        .tick(tick_w[0]), .score_bcd(score_w[0]), .high_bcd(high_w[0]),
        .saturated(sat_w[0]), .overflow(ovf_w[0]));

    score_counter_bcd #(.TICK_DIV(4), .DIGITS(2), .PTS_W(4), .WRAP_MODE(1)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .run(run_a[1]), .clear(clear_a[1]),
        .bonus_valid(bval_a[1]), .bonus_pts(bpts_a[1]), .bonus_ready(ready_w[1]),
        .tick(tick_w[1]), .score_bcd(score_w[1]), .high_bcd(high_w[1]),
        .saturated(sat_w[1]), .overflow(ovf_w[1]));

    score_counter_bcd #(.TICK_DIV(1000), .DIGITS(2), .PTS_W(4), .WRAP_MODE(0)) dut_slow (
        .clk(clk), .rst_n(rst_n), .run(run_a[2]), .clear(clear_a[2]),
        .bonus_valid(bval_a[2]), .bonus_pts(bpts_a[2]), .bonus_ready(ready_w[2]),
        .tick(tick_w[2]), .score_bcd(score_w[2]), .high_bcd(high_w[2]),
        .saturated(sat_w[2]), .overflow(ovf_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h, expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- behavioural model (integer score, integer pending) ---
    int m_score [3];
    int m_high  [3];
    int m_pend  [3];
    int m_presc [3];
    bit m_tick  [3];
    bit m_sat   [3];
    bit m_ovf   [3];
    int m_pold;
    bit m_th;
    bit m_ds;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m_score[k] = 0; m_high[k] = 0; m_pend[k] = 0; m_presc[k] = 0;
                m_tick[k] = 0;  m_sat[k] = 0;  m_ovf[k] = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                m_pold   = m_pend[k];
                m_tick[k] = 0;
                m_ovf[k]  = 0;
                if (clear_a[k]) begin
                    if (m_score[k] > m_high[k]) m_high[k] = m_score[k];
                    m_score[k] = 0; m_pend[k] = 0; m_presc[k] = 0; m_sat[k] = 0;
                end else begin
                    m_th = run_a[k] && (m_presc[k] == tdiv[k] - 1);
                    if (run_a[k]) m_presc[k] = m_th ? 0 : m_presc[k] + 1;
                    m_tick[k] = m_th;
                    m_ds = run_a[k] && !m_th && (m_pold > 0);
                    if (m_ds) m_pend[k] = m_pold - 1;
                    if (m_pold == 0 && bval_a[k]) m_pend[k] = int'(bpts_a[k]);
                    if (m_th || m_ds) begin
                        if (m_score[k] == MAXV) begin
                            if (wraps[k] != 0) begin
                                m_score[k] = 0;
                                m_ovf[k]   = 1;
                            end else begin
                                m_sat[k] = 1;
                            end
                        end else begin
                            m_score[k] = m_score[k] + 1;
                        end
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("m_score", k, score_w[k], to_bcd(m_score[k]));
            chk("m_high",  k, high_w[k],  to_bcd(m_high[k]));
            chk("m_tick",  k, tick_w[k],  m_tick[k]);
            chk("m_sat",   k, sat_w[k],   m_sat[k]);
            chk("m_ovf",   k, ovf_w[k],   m_ovf[k]);
            chk("m_ready", k, ready_w[k], (m_pend[k] == 0) && !clear_a[k]);
        end
    end

    // ---------------- directed helpers ------------------------------------
    task automatic bonus(input int k, input int pts);
        bval_a[k] = 1'b1;
        bpts_a[k] = 4'(pts);
        cyc(1);
        bval_a[k] = 1'b0;
        cyc(pts);
    endtask

    task automatic clear_pulse(input int k, input bit with_bonus);
        clear_a[k] = 1'b1;
        if (with_bonus) begin
            bval_a[k] = 1'b1;
            bpts_a[k] = 4'd5;
        end
        #1;
        chk("ready_in_clear", k, ready_w[k], 0);
        cyc(1);
        clear_a[k] = 1'b0;
        bval_a[k]  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------------------------
    initial begin
        int  tcnt;
        bit  ready_ok;
        bit  found;
        bit  ovf_seen;
        int  lowcnt;

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            run_a[k] = 0; clear_a[k] = 0; bval_a[k] = 0; bpts_a[k] = '0;
        end
        cyc(2);
        chk("rst_score", 0, score_w[0], 8'h00);
        chk("rst_high",  0, high_w[0],  8'h00);
        chk("rst_ready", 0, ready_w[0], 1);
        rst_n = 1'b1;

        // Ticks only: 40 cycles at TICK_DIV=4 -> 10 ticks, score 10.
        run_a[0] = 1'b1;
        tcnt = 0;
        ready_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (tick_w[0]) tcnt++;
            if (!ready_w[0]) ready_ok = 1'b0;
        end
        chk("tick_count", 0, tcnt, 10);
        chk("score_40cyc", 0, score_w[0], 8'h10);
        chk("ready_40cyc", 0, ready_ok, 1);

        // Saturation at 99.
        found = 1'b0;
        ovf_seen = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            cyc(1);
            if (score_w[0] == 8'h98) found = 1'b1;
            if (ovf_w[0]) ovf_seen = 1'b1;
        end
        chk("reach_98", 0, found, 1);
        cyc(4);
        chk("score_99", 0, score_w[0], 8'h99);
        chk("sat_before", 0, sat_w[0], 0);
        cyc(4);
        chk("score_hold", 0, score_w[0], 8'h99);
        chk("sat_after", 0, sat_w[0], 1);
        chk("ovf_never", 0, ovf_seen | ovf_w[0], 0);
        run_a[0] = 1'b0;
        clear_pulse(0, 1'b0);
        chk("clr_score", 0, score_w[0], 8'h00);
        chk("clr_sat",   0, sat_w[0],   0);
        chk("clr_high",  0, high_w[0],  8'h99);

        // Bonus 3 overlapping a tick: 0 + 3 + 1 tick = 4.
        run_a[0]  = 1'b1;
        bval_a[0] = 1'b1;
        bpts_a[0] = 4'd3;
        cyc(1);
        bval_a[0] = 1'b0;
        cyc(3);
        chk("ovl_tick",  0, tick_w[0],  1);
        chk("ovl_score", 0, score_w[0], 8'h03);
        chk("ovl_ready", 0, ready_w[0], 0);
        cyc(1);
        chk("ovl_final", 0, score_w[0], 8'h04);
        chk("ovl_done",  0, ready_w[0], 1);
        run_a[0] = 1'b0;

        // Wrap mode: 99 -> 00 with a single overflow pulse.
        run_a[1] = 1'b1;
        found = 1'b0;
        ovf_seen = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            cyc(1);
            if (score_w[1] == 8'h99) found = 1'b1;
            if (ovf_w[1]) ovf_seen = 1'b1;
        end
        chk("reach_99", 1, found, 1);
        chk("no_early_ovf", 1, ovf_seen, 0);
        cyc(4);
        chk("wrap_score", 1, score_w[1], 8'h00);
        chk("wrap_ovf",   1, ovf_w[1],   1);
        chk("wrap_high",  1, high_w[1],  8'h00);
        cyc(1);
        chk("ovf_1cyc", 1, ovf_w[1], 0);
        cyc(2);
        clear_pulse(1, 1'b0);
        chk("clr_tick_drop",  1, tick_w[1],  0);
        chk("clr_tick_score", 1, score_w[1], 8'h00);
        run_a[1] = 1'b0;

        // Slow prescaler: bonus drain behaviour.
        run_a[2] = 1'b1;
        bonus(2, 7);
        chk("bonus7", 2, score_w[2], 8'h07);
        chk("bonus7_rdy", 2, ready_w[2], 1);
        bval_a[2] = 1'b1;
        bpts_a[2] = 4'd5;
        cyc(1);
        bpts_a[2] = 4'd9;
        lowcnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (!ready_w[2]) lowcnt++;
            if (i == 3) bval_a[2] = 1'b0;
            cyc(1);
        end
        chk("bonus5_score", 2, score_w[2], 8'h12);
        chk("bonus5_low",   2, lowcnt, 5);
        chk("bonus5_rdy",   2, ready_w[2], 1);
        cyc(3);
        chk("second_rejected", 2, score_w[2], 8'h12);

        bval_a[2] = 1'b1;
        bpts_a[2] = 4'd4;
        cyc(1);
        bval_a[2] = 1'b0;
        cyc(2);
        run_a[2] = 1'b0;
        cyc(3);
        chk("pause_score", 2, score_w[2], 8'h14);
        chk("pause_rdy",   2, ready_w[2], 0);
        run_a[2] = 1'b1;
        cyc(2);
        chk("resume_score", 2, score_w[2], 8'h16);
        chk("resume_rdy",   2, ready_w[2], 1);

        // High-score latching.
        clear_pulse(2, 1'b1);
        cyc(3);
        chk("clr_bonus_rej", 2, score_w[2], 8'h00);
        chk("high_16",       2, high_w[2],  8'h16);
        bonus(2, 15);
        bonus(2, 15);
        clear_pulse(2, 1'b0);
        chk("high_30", 2, high_w[2], 8'h30);
        bonus(2, 15);
        bonus(2, 15);
        bonus(2, 12);
        chk("score_42", 2, score_w[2], 8'h42);
        clear_pulse(2, 1'b0);
        chk("high_42",   2, high_w[2],  8'h42);
        chk("score_clr", 2, score_w[2], 8'h00);
        bonus(2, 10);
        chk("score_10", 2, score_w[2], 8'h10);
        clear_pulse(2, 1'b0);
        chk("high_keep", 2, high_w[2], 8'h42);

        // Asynchronous reset in the middle of a drain.
        bval_a[2] = 1'b1;
        bpts_a[2] = 4'd9;
        cyc(1);
        bval_a[2] = 1'b0;
        cyc(2);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("arst_score", k, score_w[k], 8'h00);
            chk("arst_high",  k, high_w[k],  8'h00);
            chk("arst_tick",  k, tick_w[k],  0);
            chk("arst_sat",   k, sat_w[k],   0);
            chk("arst_ovf",   k, ovf_w[k],   0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc(3);
        run_a[2] = 1'b0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/score_counter_bcd.md
Name: score_counter_bcd

Overview:
- Parametrised game-score engine: prescaled auto-increment ticks plus handshaked bonus-point injection, held in packed BCD for direct seven-segment/HUD rendering.
- Tracks a high score, latched on round clear; selectable saturate or wrap at the maximum value.
- Sits between game-logic event sources and the display/HUD renderer. Single clock domain.

Parameters:
- TICK_DIV, 50_000_000, clk cycles per auto-increment tick (>=2); prescaler width = $clog2(TICK_DIV).
- DIGITS, 4, number of BCD digits; max score = 10^DIGITS - 1.
- PTS_W, 4, width of the binary bonus_pts input.
- WRAP_MODE, 0, 0 = saturate at max; 1 = wrap to zero and pulse overflow.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  1 = counting enabled; 0 = pause (prescaler and bonus drain frozen).
- clear  in  1  synchronous round clear: high-score update, then zero score.
- bonus_valid  in  1  bonus request.
- bonus_pts  in  PTS_W  bonus points, binary.
- bonus_ready  out  1  bonus can be accepted this cycle.
- tick  out  1  one-cycle pulse on each prescaler terminal count.
- score_bcd  out  4*DIGITS  current score, packed BCD, digit 0 in bits [3:0].
- high_bcd  out  4*DIGITS  high score, packed BCD.
- saturated  out  1  sticky; set when an increment is blocked at max (WRAP_MODE=0 only).
- overflow  out  1  one-cycle pulse on wrap to zero (WRAP_MODE=1 only).

Behaviour:
- Reset (async, rst_n=0): prescaler=0, pending=0, score_bcd=0, high_bcd=0, saturated=0, overflow=0, tick=0. bonus_ready goes to 1 on release.
- Prescaler:
  - While run=1, counts 0..TICK_DIV-1.
  - At TICK_DIV-1: wraps to 0, tick=1 in that same cycle (registered, so visible the following cycle), score increment request asserted.
  - run=0 holds the prescaler value; no ticks.
- Bonus handshake:
  - bonus_ready = (pending==0) && !clear. Combinational; no dependence on bonus_valid.
  - Transfer when bonus_valid && bonus_ready: pending <= bonus_pts.
  - bonus_pts=0 is accepted and is a no-op.
- Drain state machine:
  - IDLE (pending==0): goes to DRAIN on a transfer with nonzero pts.
  - DRAIN: each cycle with run=1 and no tick increment, score += 1 and pending -= 1. Returns to IDLE when pending reaches 0.
- Score arithmetic:
  - At most +1 per cycle. A tick takes priority over a drain step; neither is ever lost. Total added = ticks + accepted bonus points exactly.
  - Increment by 1 is a BCD carry chain: a digit at 9 becomes 0 and carries.
- At max (all digits 9), increment requested:
  - WRAP_MODE=0: score holds, saturated <= 1 (sticky until clear or reset). The drain still decrements pending, so bonus points are consumed.
  - WRAP_MODE=1: score <= 0, overflow pulses 1 cycle.
- clear=1 (priority over tick, drain and bonus):
  - If score_bcd > high_bcd, high_bcd <= score_bcd (digit-wise MSD-first compare, which equals numeric compare).
  - score <= 0, pending <= 0, prescaler <= 0, saturated <= 0.
  - A bonus presented during clear is not accepted.
  - A tick coinciding with clear is discarded.
- Latency: score_bcd is registered and reflects an increment one cycle after the tick/drain cycle.

Decomposition:
- Package score_pkg:
  - BCD_W=4, BCD_MAX=4'd9.
  - Function bcd_gt(a,b) for packed BCD compare.
  - Drain-state enum {S_IDLE, S_DRAIN}.
- Sub-module bcd_incrementer: combinational, parameter DIGITS. Inputs packed BCD; outputs value+1 and carry_out (carry_out=1 iff input is all 9s). Instantiated once.

Test Plan:
- TICK_DIV=4, DIGITS=2, run=1 for 40 cycles after reset -> tick every 4th cycle, 10 ticks, score_bcd=8'h10, bonus_ready=1 throughout.
- WRAP_MODE=0, score reaches 8'h98, two more ticks -> score 8'h99 and holds, saturated=1, overflow never asserts; clear -> saturated=0, score 8'h00.
- WRAP_MODE=1, score 8'h99, one tick -> score 8'h00, overflow high exactly 1 cycle, high_bcd unchanged.
- TICK_DIV=1000, score 8'h07, bonus_pts=5 accepted -> score 8'h12 five cycles later; bonus_ready low for 5 cycles; a second bonus_valid during the drain is not accepted. Then run=0 mid-drain -> score frozen, drain resumes when run returns to 1.
- TICK_DIV=4, bonus 3 accepted so the drain overlaps a tick -> final score = start + 3 + ticks elapsed; the tick cycle shows no drain step.
- Score 8'h42, high 8'h30, clear -> high 8'h42, score 0; later score 8'h10, clear -> high stays 8'h42. rst_n=0 mid-drain -> all outputs 0 immediately (async).
